// File: rtl/enigma_rotor_bank.sv
// Multi-rotor Enigma-style Caesar core: odometer-stepped rotor bank whose summed
// positions give the shift applied to one ASCII letter per handshake.
module enigma_rotor_bank #(
   parameter int NUM_ROTORS = 3,
   parameter int ROTOR_W    = 5
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          load_init_state,
   input  logic [NUM_ROTORS*ROTOR_W-1:0] rotor_init_state,
   input  logic                          encrypt,
   input  logic [7:0]                    char_input,
   input  logic                          char_valid,
   output logic                          char_ready,
   output logic [7:0]                    letter_out,
   output logic                          letter_valid,
   output logic [NUM_ROTORS*ROTOR_W-1:0] rotor_state
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACCUM = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [2:0]         LAST_IDX = 3'(NUM_ROTORS - 1);
   localparam logic [ROTOR_W-1:0] MAX_POS  = ROTOR_W'(25);
   localparam logic [ROTOR_W-1:0] MODULUS  = ROTOR_W'(26);

   logic [1:0]         state;
   logic [ROTOR_W-1:0] rotor   [NUM_ROTORS];
   logic [ROTOR_W-1:0] stepped [NUM_ROTORS];
   logic [ROTOR_W-1:0] loaded  [NUM_ROTORS];
   logic [ROTOR_W-1:0] acc;
   logic [ROTOR_W-1:0] acc_next;
   logic [ROTOR_W-1:0] pos_sel;
   logic [ROTOR_W:0]   acc_sum;
   logic [2:0]         idx;
   logic [7:0]         char_q;
   logic               enc_q;
   logic               carry;
   logic               accept;

   logic               upper_q;
   logic               letter_q;
   logic [7:0]         base;
   logic [7:0]         offset;
   logic [ROTOR_W:0]   shifted;
   logic [ROTOR_W:0]   reduced;
   logic [7:0]         cipher;

   function automatic logic is_letter(input logic [7:0] c);
      return (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A);
   endfunction

   assign char_ready = (state == IDLE) && !load_init_state && !letter_valid;
   assign accept     = char_valid && char_ready;

   // NOTE: blocking assignments in always_comb let the carry ripple through the
   // loop within a single evaluation; each variable gets a default first so no latch forms.
   always_comb begin
      carry = 1'b1;
      for (int i = 0; i < NUM_ROTORS; i++) begin
         stepped[i] = rotor[i];
         if (carry) stepped[i] = (rotor[i] == MAX_POS) ? '0 : rotor[i] + 1'b1;
         carry = carry && (rotor[i] == MAX_POS);
      end
   end

   always_comb begin
      rotor_state = '0;
      pos_sel     = '0;
      for (int i = 0; i < NUM_ROTORS; i++) begin
         loaded[i] = (rotor_init_state[i*ROTOR_W +: ROTOR_W] >= MODULUS)
                   ? rotor_init_state[i*ROTOR_W +: ROTOR_W] - MODULUS
                   : rotor_init_state[i*ROTOR_W +: ROTOR_W];
         rotor_state[i*ROTOR_W +: ROTOR_W] = rotor[i];
         if (idx == 3'(i)) pos_sel = rotor[i];
      end
   end

   // Running sum stays in 0..25 by a single compare-and-subtract per rotor.
   assign acc_sum  = {1'b0, acc} + {1'b0, pos_sel};
   assign acc_next = (acc_sum >= {1'b0, MODULUS}) ? ROTOR_W'(acc_sum - {1'b0, MODULUS})
                                                  : acc_sum[ROTOR_W-1:0];

   assign upper_q  = (char_q >= 8'h41) && (char_q <= 8'h5A);
   assign letter_q = is_letter(char_q);
   assign base     = upper_q ? 8'h41 : 8'h61;
   assign offset   = char_q - base;
   assign shifted  = enc_q ? ({1'b0, offset[ROTOR_W-1:0]} + {1'b0, acc})
                           : ({1'b0, offset[ROTOR_W-1:0]} + {1'b0, MODULUS} - {1'b0, acc});
   assign reduced  = (shifted >= {1'b0, MODULUS}) ? shifted - {1'b0, MODULUS} : shifted;
   assign cipher   = letter_q ? base + 8'(reduced) : char_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         acc          <= '0;
         idx          <= '0;
         char_q       <= '0;
         enc_q        <= 1'b0;
         letter_out   <= 8'h00;
         letter_valid <= 1'b0;
         // NOTE: the rotor bank is architectural key state, so every entry is reset
         // explicitly rather than treated as an uninitialised memory.
         for (int i = 0; i < NUM_ROTORS; i++) rotor[i] <= '0;
      end else begin
         letter_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (load_init_state) begin
                  rotor <= loaded;
               end else if (accept) begin
                  char_q <= char_input;
                  enc_q  <= encrypt;
                  acc    <= '0;
                  idx    <= '0;
                  if (is_letter(char_input)) begin
                     rotor <= stepped;
                     state <= ACCUM;
                  end else begin
                     state <= DONE;
                  end
               end
            end
            ACCUM: begin
               acc <= acc_next;
               idx <= idx + 3'd1;
               if (idx == LAST_IDX) state <= DONE;
            end
            DONE: begin
               letter_out   <= cipher;
               letter_valid <= 1'b1;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_enigma_rotor_bank.sv
// Scoreboard bench for enigma_rotor_bank: expected letters and due cycles are queued
// at accept and compared when letter_valid pulses.
module tb_enigma_rotor_bank;

   localparam int NR = 3;
   localparam int W  = 5;

   logic            clk = 1'b0;
   logic            reset;
   logic            load_init_state;
   logic [NR*W-1:0] rotor_init_state;
   logic            encrypt;
   logic [7:0]      char_input;
   logic            char_valid;
   logic            char_ready;
   logic [7:0]      letter_out;
   logic            letter_valid;
   logic [NR*W-1:0] rotor_state;

   typedef struct {
      logic [7:0] ch;
      int         due;
   } exp_t;

   exp_t sb[$];
   int   m_rot[NR];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   byte  hello[5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
   byte  ct[5];
   byte  dummy;

   enigma_rotor_bank #(.NUM_ROTORS(NR), .ROTOR_W(W)) dut (
      .clk              (clk),
      .reset            (reset),
      .load_init_state  (load_init_state),
      .rotor_init_state (rotor_init_state),
      .encrypt          (encrypt),
      .char_input       (char_input),
      .char_valid       (char_valid),
      .char_ready       (char_ready),
      .letter_out       (letter_out),
      .letter_valid     (letter_valid),
      .rotor_state      (rotor_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit is_letter(input byte c);
      return (c >= 65 && c <= 90) || (c >= 97 && c <= 122);
   endfunction

   function automatic byte cipher(input byte c, input bit enc, input int sh);
      int b;
      int l;
      if (!is_letter(c)) return c;
      b = (c <= 90) ? 65 : 97;
      l = int'(c) - b;
      return byte'(b + (enc ? (l + sh) % 26 : (l - sh + 26) % 26));
   endfunction

   function automatic logic [NR*W-1:0] model_state();
      logic [NR*W-1:0] r;
      r = '0;
      for (int i = 0; i < NR; i++) r[i*W +: W] = W'(m_rot[i]);
      return r;
   endfunction

   function automatic int model_shift();
      int s;
      s = 0;
      for (int i = 0; i < NR; i++) s = (s + m_rot[i]) % 26;
      return s;
   endfunction

   task automatic model_step();
      bit c;
      c = 1'b1;
      for (int i = 0; i < NR; i++) begin
         if (c) begin
            c        = (m_rot[i] == 25);
            m_rot[i] = c ? 0 : m_rot[i] + 1;
         end
      end
   endtask

   // Monitor: every valid pulse must match the oldest queued expectation and its due cycle.
   always @(negedge clk) begin : mon
      exp_t e;
      if (letter_valid === 1'b1) begin
         check("ready_low_while_valid", 32'(char_ready), 32'd0);
         if (sb.size() == 0) begin
            check("unexpected_valid", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("letter_out", 32'(letter_out), 32'(e.ch));
            check("latency", 32'(cyc), 32'(e.due));
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      @(negedge clk);
      while (char_ready !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (char_ready !== 1'b1) check("ready_timeout", 32'(char_ready), 32'd1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() > 0) check("drain_timeout", 32'(sb.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic load_rotors(input int v0, input int v1, input int v2);
      int v[NR];
      v = '{v0, v1, v2};
      wait_ready();
      for (int i = 0; i < NR; i++) rotor_init_state[i*W +: W] = W'(v[i]);
      load_init_state = 1'b1;
      @(posedge clk);
      #1;
      load_init_state = 1'b0;
      for (int i = 0; i < NR; i++) m_rot[i] = (v[i] >= 26) ? v[i] - 26 : v[i];
      check("load_state", 32'(rotor_state), 32'(model_state()));
   endtask

   // exp_ch < 0 takes the expected character from the model; mc returns the model cipher.
   task automatic send_char(input byte c, input bit enc, input int exp_ch, output byte mc);
      exp_t e;
      wait_ready();
      char_input = c;
      encrypt    = enc;
      char_valid = 1'b1;
      @(posedge clk);
      #1;
      char_valid = 1'b0;
      char_input = 8'h3F;
      encrypt    = ~enc;
      if (is_letter(c)) model_step();
      mc    = cipher(c, enc, model_shift());
      e.ch  = (exp_ch >= 0) ? 8'(exp_ch) : mc;
      e.due = cyc + (is_letter(c) ? NR + 1 : 1);
      sb.push_back(e);
      check("rotor_step", 32'(rotor_state), 32'(model_state()));
   endtask

   initial begin
      reset            = 1'b1;
      load_init_state  = 1'b0;
      rotor_init_state = '0;
      encrypt          = 1'b0;
      char_input       = 8'h00;
      char_valid       = 1'b0;
      for (int i = 0; i < NR; i++) m_rot[i] = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_letter_out", 32'(letter_out), 32'h00);
      check("rst_letter_valid", 32'(letter_valid), 32'd0);
      check("rst_char_ready", 32'(char_ready), 32'd1);
      check("rst_rotor_state", 32'(rotor_state), 32'd0);

      load_rotors(0, 0, 0);
      send_char("A", 1'b1, 8'h42, dummy);
      check("rot_after_A", 32'(rotor_state), 32'({5'd0, 5'd0, 5'd1}));
      drain();

      load_rotors(25, 25, 3);
      send_char("A", 1'b1, 8'h45, dummy);
      check("carry_chain", 32'(rotor_state), 32'({5'd4, 5'd0, 5'd0}));
      drain();
      load_rotors(25, 25, 25);
      send_char("A", 1'b1, 8'h41, dummy);
      check("carry_wrap_all", 32'(rotor_state), 32'd0);
      drain();

      load_rotors(7, 2, 0);
      for (int i = 0; i < 5; i++) send_char(hello[i], 1'b1, -1, ct[i]);
      drain();
      load_rotors(7, 2, 0);
      for (int i = 0; i < 5; i++) send_char(ct[i], 1'b0, int'(hello[i]), dummy);
      drain();

      load_rotors(0, 0, 0);
      send_char("z", 1'b1, 8'h61, dummy);
      drain();
      load_rotors(0, 0, 0);
      send_char("a", 1'b0, 8'h7A, dummy);
      drain();

      load_rotors(3, 4, 5);
      send_char("5", 1'b1, 8'h35, dummy);
      send_char("!", 1'b0, 8'h21, dummy);
      drain();
      check("passthru_rotors", 32'(rotor_state), 32'({5'd5, 5'd4, 5'd3}));

      // char_valid held through the whole busy window must yield a single accept.
      load_rotors(0, 0, 0);
      wait_ready();
      char_input = "C";
      encrypt    = 1'b1;
      char_valid = 1'b1;
      @(posedge clk);
      #1;
      model_step();
      sb.push_back('{ch: 8'h44, due: cyc + NR + 1});
      @(negedge clk);
      check("ready_busy", 32'(char_ready), 32'd0);
      repeat (NR + 1) @(posedge clk);
      #1;
      char_valid = 1'b0;
      drain();
      check("held_valid_one_step", 32'(rotor_state), 32'(model_state()));

      // Load while busy is ignored and not replayed later.
      load_rotors(0, 0, 0);
      send_char("A", 1'b1, 8'h42, dummy);
      for (int i = 0; i < NR; i++) rotor_init_state[i*W +: W] = 5'd9;
      load_init_state = 1'b1;
      @(posedge clk);
      #1;
      load_init_state = 1'b0;
      drain();
      repeat (2) @(posedge clk);
      #1;
      check("busy_load_ignored", 32'(rotor_state), 32'({5'd0, 5'd0, 5'd1}));

      // Reset two cycles after accept drops the character in flight.
      load_rotors(0, 0, 0);
      wait_ready();
      char_input = "A";
      encrypt    = 1'b1;
      char_valid = 1'b1;
      @(posedge clk);
      #1;
      char_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < NR; i++) m_rot[i] = 0;
      repeat (NR + 3) @(negedge clk);
      check("midrst_letter_out", 32'(letter_out), 32'h00);
      check("midrst_letter_valid", 32'(letter_valid), 32'd0);
      check("midrst_char_ready", 32'(char_ready), 32'd1);
      check("midrst_rotor_state", 32'(rotor_state), 32'd0);

      load_rotors(30, 0, 0);
      check("load_30_reduced", 32'(rotor_state[W-1:0]), 32'd4);
      send_char("A", 1'b1, 8'h46, dummy);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
